// File: rtl/lsl8_pkg.sv
// Shared types and constants for the 8-bit sequential logical shift-left unit.
package lsl8_pkg;

    localparam int WIDTH    = 8;
    localparam int SHAMT_W  = 3;
    localparam int STEP_MAX = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/lsl8_seq_if.sv
// Start/done handshake and data bus for lsl8_seq.
// Optional ovf signal is present only when LSL8_SEQ_OVF_EN is defined.
interface lsl8_seq_if;
    import lsl8_pkg::*;

    logic               start;
    logic [WIDTH-1:0]   d_in;
    logic [SHAMT_W-1:0] shamt;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   d_out;
`ifdef LSL8_SEQ_OVF_EN
    logic               ovf;
`endif

    modport master (
        output start, d_in, shamt,
`ifdef LSL8_SEQ_OVF_EN
        input  ovf,
`endif
        input  busy, done, d_out
    );

    modport slave (
        input  start, d_in, shamt,
`ifdef LSL8_SEQ_OVF_EN
        output ovf,
`endif
        output busy, done, d_out
    );

endinterface

// File: rtl/lsl8_seq_lsl8.sv
// Combinational 8-bit logical shift left by 0..3, one 4:1 mux per output bit,
// zero fill on the low side (mirror of the shift-right mux structure).
module mx4 (
    input  logic [3:0] d_i,
    input  logic [1:0] s_i,
    output logic       y_o
);
    assign y_o = d_i[s_i];
endmodule

module lsl8 (
    input  logic [7:0] a_i,
    input  logic [1:0] sh_i,
    output logic [7:0] y_o
);
    for (genvar i = 0; i < 8; i++) begin : g_bit
        logic [3:0] taps;
        for (genvar j = 0; j < 4; j++) begin : g_tap
            if (i >= j) begin : g_src
                assign taps[j] = a_i[i-j];
            end else begin : g_zero
                assign taps[j] = 1'b0;
            end
        end
        mx4 u_mx (
            .d_i (taps),
            .s_i (sh_i),
            .y_o (y_o[i])
        );
    end
endmodule

// File: rtl/lsl8_seq.sv
// Multi-cycle 8-bit logical shift-left, at most 3 positions per clock.
// Define LSL8_SEQ_OVF_EN to add the sticky ovf (bit shifted out of bit 7) flag.
module lsl8_seq
    import lsl8_pkg::*;
#(
    parameter int P_WIDTH    = WIDTH,
    parameter int P_SHAMT_W  = SHAMT_W,
    parameter int P_STEP_MAX = STEP_MAX
) (
    input  logic        clk,
    input  logic        reset,
    lsl8_seq_if.slave   bus
);

    if (P_WIDTH != 8) begin : g_width_chk
        $error("lsl8_seq: only WIDTH=8 is supported");
    end
    if (P_SHAMT_W != $clog2(P_WIDTH)) begin : g_shamt_chk
        $error("lsl8_seq: SHAMT_W must equal log2(WIDTH)");
    end
    if (P_STEP_MAX != 3) begin : g_step_chk
        $error("lsl8_seq: STEP_MAX is fixed at 3 by the 2-bit stage select");
    end

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic [SHAMT_W-1:0] rem_q, rem_d;
    logic [1:0]         step;
    logic [WIDTH-1:0]   shifted;

    assign step = (rem_q > 3'd3) ? 2'd3 : rem_q[1:0];

    lsl8 u_lsl8 (
        .a_i  (data_q),
        .sh_i (step),
        .y_o  (shifted)
    );

`ifdef LSL8_SEQ_OVF_EN
    logic ovf_q, ovf_d;
    logic lost;

    // Top `step` bits of data_q are the ones pushed past bit 7 this cycle.
    assign lost = (data_q[7] & (step >= 2'd1)) |
                  (data_q[6] & (step >= 2'd2)) |
                  (data_q[5] & (step == 2'd3));
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            data_q  <= '0;
            rem_q   <= '0;
`ifdef LSL8_SEQ_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            data_q  <= data_d;
            rem_q   <= rem_d;
`ifdef LSL8_SEQ_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        data_d  = data_q;
        rem_d   = rem_q;
`ifdef LSL8_SEQ_OVF_EN
        ovf_d   = ovf_q;
`endif
        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    data_d  = bus.d_in;
                    rem_d   = bus.shamt;
`ifdef LSL8_SEQ_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                data_d = shifted;
                rem_d  = rem_q - {1'b0, step};
`ifdef LSL8_SEQ_OVF_EN
                ovf_d  = ovf_q | lost;
`endif
                if (rem_d == '0) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign bus.busy  = (state_q != IDLE);
    assign bus.done  = (state_q == DONE);
    assign bus.d_out = data_q;
`ifdef LSL8_SEQ_OVF_EN
    assign bus.ovf   = ovf_q;
`endif

endmodule

// File: tb/tb_lsl8_seq.sv
// Directed self-checking bench for lsl8_seq; checks ovf when LSL8_SEQ_OVF_EN is defined.
module tb_lsl8_seq;
    import lsl8_pkg::*;

    logic clk;
    logic reset;
    int   compared;
    int   mismatched;

    lsl8_seq_if bus ();

    lsl8_seq dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %02h expected %02h", tag, obs, exp);
        end
    endtask

    // Start one op, wait for done, check latency, result and return to IDLE.
    task automatic run_op(input string tag, input logic [7:0] d, input logic [2:0] sh,
                          input logic [7:0] exp, input logic exp_ovf, input int n);
        int e;
        bus.start = 1'b1;
        bus.d_in  = d;
        bus.shamt = sh;
        tick();
        bus.start = 1'b0;
        bus.d_in  = ~d;
        bus.shamt = ~sh;
        check({tag, " busy_after_start"}, {7'd0, bus.busy}, 8'd1);
        e = 0;
        while (!bus.done && e < 20) begin
            tick();
            e++;
        end
        check({tag, " latency"}, e[7:0], n[7:0]);
        check({tag, " d_out"}, bus.d_out, exp);
`ifdef LSL8_SEQ_OVF_EN
        check({tag, " ovf"}, {7'd0, bus.ovf}, {7'd0, exp_ovf});
`else
        if (exp_ovf === 1'bx) $error("FAIL %s: bad ovf expectation", tag);
`endif
        tick();
        check({tag, " idle_after_done"}, {6'd0, bus.busy, bus.done}, 8'd0);
        check({tag, " d_out_held"}, bus.d_out, exp);
    endtask

    initial begin
        compared   = 0;
        mismatched = 0;
        reset      = 1'b1;
        bus.start  = 1'b0;
        bus.d_in   = '0;
        bus.shamt  = '0;
        tick();
        tick();
        check("reset_state", {bus.busy, bus.done, bus.d_out[5:0]}, 8'd0);
        check("reset_d_out", bus.d_out, 8'h00);
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("idle_no_start", {7'd0, bus.busy}, 8'd0);

        // Reset during the second SHIFT cycle of a 7-position shift
        bus.start = 1'b1;
        bus.d_in  = 8'hFF;
        bus.shamt = 3'd7;
        tick();
        bus.start = 1'b0;
        tick();
        check("midop_busy", {7'd0, bus.busy}, 8'd1);
        check("midop_d_out", bus.d_out, 8'hF8);
        #2;
        reset = 1'b1;
        #1;
        check("rst_async_flags", {6'd0, bus.busy, bus.done}, 8'd0);
        check("rst_async_d_out", bus.d_out, 8'h00);
        tick();
        @(negedge clk);
        reset = 1'b0;
        tick();
        check("rst_release_idle", {6'd0, bus.busy, bus.done}, 8'd0);

        run_op("x81_s1", 8'h81, 3'd1, 8'h02, 1'b1, 1);
        run_op("x0F_s4", 8'h0F, 3'd4, 8'hF0, 1'b0, 2);
        run_op("xFF_s7", 8'hFF, 3'd7, 8'h80, 1'b1, 3);
        run_op("xA5_s0", 8'hA5, 3'd0, 8'hA5, 1'b0, 1);
        run_op("xC3_s6", 8'hC3, 3'd6, 8'hC0, 1'b1, 2);
        run_op("x01_s3", 8'h01, 3'd3, 8'h08, 1'b0, 1);

        // start held high: only IDLE-cycle operands count, ops spaced N+2 edges
        bus.start = 1'b1;
        bus.d_in  = 8'h0F;
        bus.shamt = 3'd4;
        tick();
        bus.d_in  = 8'hFF;
        bus.shamt = 3'd7;
        check("held_capture", bus.d_out, 8'h0F);
        tick();
        check("held_mid", bus.d_out, 8'h78);
        tick();
        check("held_done1", {6'd0, bus.busy, bus.done}, 8'd3);
        check("held_res1", bus.d_out, 8'hF0);
        tick();
        check("held_idle_gap", {6'd0, bus.busy, bus.done}, 8'd0);
        check("held_res1_kept", bus.d_out, 8'hF0);
        bus.d_in  = 8'h33;
        bus.shamt = 3'd2;
        tick();
        check("held_accept2", {7'd0, bus.busy}, 8'd1);
        check("held_capture2", bus.d_out, 8'h33);
        bus.d_in  = 8'h55;
        bus.shamt = 3'd5;
        tick();
        check("held_done2", {7'd0, bus.done}, 8'd1);
        check("held_res2", bus.d_out, 8'hCC);
`ifdef LSL8_SEQ_OVF_EN
        check("held_ovf2", {7'd0, bus.ovf}, 8'd0);
`endif
        bus.start = 1'b0;
        tick();
        check("held_end_idle", {6'd0, bus.busy, bus.done}, 8'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/lsl8_seq.md
Name: lsl8_seq

Overview:
Multi-cycle 8-bit logical shift-left unit with a start/done handshake, the left-shift counterpart of the 8-bit logical shift-right datapath.
- Accepts a 3-bit shift amount (0..7).
- Shifts by at most 3 positions per clock, using one combinational 0..3 left-shift stage.
- Sits beside the shift-right block in the shifter group. The ALU sequencer drives it and waits for done.

Parameters:
WIDTH, 8, data width; only 8 is supported. Elaboration error otherwise.
SHAMT_W, 3, shift-amount width; must equal log2(WIDTH).
STEP_MAX, 3, maximum shift applied per cycle; fixed by the 2-bit stage select.

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-high reset
start  input  1  request pulse; sampled only in IDLE
d_in  input  8  operand; captured when start is accepted
shamt  input  3  shift amount; captured when start is accepted
busy  output  1  high whenever state != IDLE
done  output  1  one-cycle pulse; result valid
d_out  output  8  result register; holds its value until the next accepted start

Behaviour:
- Interface: one clock, clk. reset is asynchronous and active-high.
- Reset (asynchronous assert, any state, including mid-shift):
  - state = IDLE; data = 0; rem = 0.
  - busy = 0; done = 0; d_out = 0.
  - Any in-flight operation is discarded.
- States:
  - IDLE: on start=1 at edge k, set data <= d_in and rem <= shamt, then go to SHIFT. start=0 keeps IDLE.
  - SHIFT: each edge, step = min(rem, 3); data <= data << step, zero-filled from the LSB; rem <= rem - step. Go to DONE when rem - step == 0, else stay in SHIFT.
  - DONE: done = 1 for this single cycle. Unconditionally return to IDLE on the next edge.
- Latency:
  - N = max(1, ceil(shamt/3)) SHIFT edges: shamt 0..3 gives N=1, 4..6 gives N=2, 7 gives N=3.
  - done is high in the cycle after edge k+N.
  - The next start can be accepted at edge k+N+2.
- shamt = 0: still takes one SHIFT cycle with step 0; result equals d_in.
- start while busy (SHIFT or DONE): ignored; d_in and shamt are not sampled.
- d_out is the data register. It is visible mid-operation but valid only when done=1 and until the next accepted start.
- done and busy are decoded from the state register; they are registered with no combinational path from start.
- Bits shifted beyond bit 7 are lost; no wrap-around (not a rotate).

Optional Feature:
Macro LSL8_SEQ_OVF_EN.
- Defined:
  - Adds an output ovf, 1 bit.
  - Sticky flag, cleared on accepted start and on reset.
  - Set when any 1 bit is shifted out of bit 7 during SHIFT. Per step, this means OR-ing the top `step` bits of data before the shift.
  - Valid with done and held until the next accepted start.
- Undefined: no ovf port and no related logic. All other behaviour is identical.

Decomposition:
- Package lsl8_pkg holds:
  - the state enum IDLE/SHIFT/DONE, 2-bit encoding;
  - the constants WIDTH=8, SHAMT_W=3, STEP_MAX=3.
- One sub-module, lsl8: combinational 8-bit logical shift left by a 2-bit amount, built from mx4 instances with zero fill on the low side, mirroring the right-shift mux structure.
  - lsl8_seq instantiates one lsl8 on the data register, with step as its select.
  - Step selection, rem update and the FSM remain in lsl8_seq.

Test Plan:
- Reset mid-operation: start d_in=0xFF, shamt=7, assert reset during the second SHIFT cycle -> busy, done and d_out are 0 immediately; IDLE after release; a new start is accepted normally.
- d_in=0x81, shamt=1 -> done in the 2nd cycle after the start edge; d_out=0x02; ovf=1 when the macro is defined.
- d_in=0x0F, shamt=4 -> N=2; done after 2 SHIFT cycles; d_out=0xF0; ovf=0.
- d_in=0xFF, shamt=7 -> steps 3,3,1; busy for 4 cycles; done after the 3rd SHIFT; d_out=0x80; ovf=1.
- d_in=0xA5, shamt=0 -> N=1; d_out=0xA5; ovf=0.
- Start held high throughout with changing d_in/shamt -> only the IDLE-cycle values are used; back-to-back operations are spaced exactly N+2 edges apart.
